// File: rtl/reel_spin_animator.sv
// Two-reel slot animator: spins both displayed indices at a fixed tick rate,
// lands the left reel first and the right reel later, then pulses done.
module reel_spin_animator #(
    parameter int unsigned TICK_DIV    = 2500000,
    parameter int unsigned NUM_SYMBOLS = 8,
    parameter int unsigned MIN_STEPS_L = 16,
    parameter int unsigned MIN_STEPS_R = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] target_left,
    input  logic [2:0] target_right,
    output logic [2:0] show_left,
    output logic [2:0] show_right,
    output logic       busy,
    output logic       left_stopped,
    output logic       right_stopped,
    output logic       done
);

    localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [2:0]    SYM_LAST  = 3'(NUM_SYMBOLS - 1);
    localparam logic [7:0]    STEPS_L   = 8'(MIN_STEPS_L);
    localparam logic [7:0]    STEPS_R   = 8'(MIN_STEPS_R);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPIN   = 3'd1,
        S_STOP_L = 3'd2,
        S_STOP_R = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic logic [2:0] sym_inc(input logic [2:0] v);
        logic [2:0] r;
        if (v >= SYM_LAST) r = 3'd0;
        else               r = v + 3'd1;
        return r;
    endfunction

    // Out-of-range targets land on symbol 0 rather than an index the ROM lacks.
    function automatic logic [2:0] sym_clamp(input logic [2:0] v);
        logic [2:0] r;
        if ({1'b0, v} >= 4'(NUM_SYMBOLS)) r = 3'd0;
        else                              r = v;
        return r;
    endfunction

    state_t        state_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]    step_q, step_d;
    logic [2:0]    tgt_l_q, tgt_r_q;
    logic [2:0]    show_l_q, show_r_q, show_l_d, show_r_d;
    logic          busy_q, lstop_q, rstop_q, done_q;
    logic          tick_s;

    // Tick strobe plus saturating/wrapping successors of the counters.
    always_comb begin
        tick_s     = 1'b0;
        tick_cnt_d = tick_cnt_q + TW'(1);
        step_d     = step_q;
        if (busy_q && (tick_cnt_q == TICK_LAST)) begin
            tick_s     = 1'b1;
            tick_cnt_d = '0;
        end else begin
            tick_s     = 1'b0;
        end
        if (step_q == 8'hFF) step_d = step_q;
        else                 step_d = step_q + 8'd1;
        show_l_d = sym_inc(show_l_q);
        show_r_d = sym_inc(show_r_q);
    end

    // Reel FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            step_q     <= 8'd0;
            tgt_l_q    <= 3'd0;
            tgt_r_q    <= 3'd0;
            show_l_q   <= 3'd0;
            show_r_q   <= 3'd0;
            busy_q     <= 1'b0;
            lstop_q    <= 1'b0;
            rstop_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (busy_q) tick_cnt_q <= tick_cnt_d;
            if (tick_s) step_q <= step_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tgt_l_q    <= sym_clamp(target_left);
                        tgt_r_q    <= sym_clamp(target_right);
                        tick_cnt_q <= '0;
                        step_q     <= 8'd0;
                        lstop_q    <= 1'b0;
                        rstop_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SPIN;
                    end
                end
                S_SPIN: begin
                    if (tick_s) begin
                        show_l_q <= show_l_d;
                        show_r_q <= show_r_d;
                        if (step_d == STEPS_L) state_q <= S_STOP_L;
                    end
                end
                S_STOP_L: begin
                    if (tick_s) begin
                        show_r_q <= show_r_d;
                        if (show_l_q == tgt_l_q) begin
                            lstop_q <= 1'b1;
                            state_q <= S_STOP_R;
                        end else begin
                            show_l_q <= show_l_d;
                        end
                    end
                end
                S_STOP_R: begin
                    // Step count here is the pre-tick value, so the earliest landing is tick MIN_STEPS_R+1.
                    if (tick_s) begin
                        if ((step_q >= STEPS_R) && (show_r_q == tgt_r_q)) begin
                            rstop_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            show_r_q <= show_r_d;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign show_left     = show_l_q;
    assign show_right    = show_r_q;
    assign busy          = busy_q;
    assign left_stopped  = lstop_q;
    assign right_stopped = rstop_q;
    assign done          = done_q;

endmodule
